// File: rtl/ntt_stream_serdes_if.sv
// rtl/ntt_stream_serdes_if.sv - serial stream, core lane and error signals of the NTT serdes.
// slave is the adapter view; master is the surrounding system view.
interface ntt_stream_serdes_if #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int SERIAL_LANES         = 1
);
   localparam int SW = SERIAL_LANES * DATA_WIDTH_PER_INPUT;
   localparam int PW = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;

   logic          s_valid;
   logic          s_ready;
   logic          s_first;
   logic [SW-1:0] s_data;
   logic [PW-1:0] core_in_data;
   logic          core_in_valid;
   logic          core_in_start;
   logic [PW-1:0] core_out_data;
   logic          core_out_valid;
   logic          core_out_start;
   logic          m_valid;
   logic          m_ready;
   logic [SW-1:0] m_data;
   logic          m_first;
   logic          m_last;
   logic          err_misalign;
   logic          err_overflow;

   modport slave (
      input  s_valid, s_first, s_data, core_out_data, core_out_valid, core_out_start, m_ready,
      output s_ready, core_in_data, core_in_valid, core_in_start,
      output m_valid, m_data, m_first, m_last, err_misalign, err_overflow
   );

   modport master (
      output s_valid, s_first, s_data, core_out_data, core_out_valid, core_out_start, m_ready,
      input  s_ready, core_in_data, core_in_valid, core_in_start,
      input  m_valid, m_data, m_first, m_last, err_misalign, err_overflow
   );
endinterface

// File: rtl/ntt_stream_serdes.sv
// rtl/ntt_stream_serdes.sv - packs serial words into NTT core beats and replays core beats serially.
// Input side: IDLE/FILL framing FSM; output side: beat FIFO plus lane-group serializer.
module ntt_stream_serdes #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int SERIAL_LANES         = 1,
   parameter int BEATS_PER_FRAME      = 32,
   parameter int OUT_FIFO_DEPTH       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   ntt_stream_serdes_if.slave     bus
);
   localparam int W      = DATA_WIDTH_PER_INPUT;
   localparam int P      = INPUT_PER_CYCLE;
   localparam int S      = SERIAL_LANES;
   localparam int GROUPS = P / S;
   localparam int GW     = $clog2(GROUPS) + 1;
   localparam int BW     = $clog2(BEATS_PER_FRAME) + 1;
   localparam int AW     = $clog2(OUT_FIFO_DEPTH);
   localparam logic [GW-1:0] LAST_GRP  = GW'(GROUPS - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_FRAME - 1);

   typedef enum logic {IDLE, FILL} in_state_t;

   in_state_t       state;
   logic [GW-1:0]   grp_ptr;
   logic [BW-1:0]   beat_cnt;
   logic [P*W-1:0]  pack_buf;
   logic [P*W-1:0]  merged;
   logic            xfer;
   logic [GW-1:0]   base_grp;
   logic [BW-1:0]   base_beat;

   // An s_first word always restarts packing at lane 0 of beat 0.
   assign xfer      = bus.s_valid & bus.s_ready;
   assign base_grp  = bus.s_first ? '0 : grp_ptr;
   assign base_beat = bus.s_first ? '0 : beat_cnt;

   always_comb begin
      merged = pack_buf;
      for (int g = 0; g < GROUPS; g++) begin
         if (base_grp == GW'(g)) merged[g*S*W +: S*W] = bus.s_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         grp_ptr           <= '0;
         beat_cnt          <= '0;
         pack_buf          <= '0;
         bus.s_ready       <= 1'b0;
         bus.core_in_valid <= 1'b0;
         bus.core_in_start <= 1'b0;
         bus.core_in_data  <= '0;
         bus.err_misalign  <= 1'b0;
      end else begin
         bus.s_ready       <= 1'b1;
         bus.core_in_valid <= 1'b0;
         bus.core_in_start <= 1'b0;
         if (xfer) begin
            if (state == IDLE && !bus.s_first) begin
               bus.err_misalign <= 1'b1;
            end else begin
               if (bus.s_first && state == FILL && (grp_ptr != '0 || beat_cnt != '0))
                  bus.err_misalign <= 1'b1;
               pack_buf <= merged;
               if (base_grp == LAST_GRP) begin
                  bus.core_in_valid <= 1'b1;
                  bus.core_in_start <= (base_beat == '0);
                  bus.core_in_data  <= merged;
                  grp_ptr           <= '0;
                  if (base_beat == LAST_BEAT) begin
                     state    <= IDLE;
                     beat_cnt <= '0;
                  end else begin
                     state    <= FILL;
                     beat_cnt <= base_beat + 1'b1;
                  end
               end else begin
                  state    <= FILL;
                  grp_ptr  <= base_grp + 1'b1;
                  beat_cnt <= base_beat;
               end
            end
         end
      end
   end

   logic [P*W-1:0]  fifo_data  [OUT_FIFO_DEPTH];
   logic            fifo_first [OUT_FIFO_DEPTH];
   logic            fifo_last  [OUT_FIFO_DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [GW-1:0]   xfer_ptr;
   logic [BW-1:0]   out_cnt;
   logic [BW-1:0]   out_idx;
   logic            out_is_last;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic [P*W-1:0]  head;

   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_idx     = bus.core_out_start ? '0 : out_cnt;
   assign out_is_last = (out_idx == LAST_BEAT);
   assign pop         = bus.m_valid & bus.m_ready & (xfer_ptr == LAST_GRP);
   // A full FIFO still accepts a beat when the head leaves in the same cycle.
   assign push        = bus.core_out_valid & (~full | pop);
   assign head        = fifo_data[rd_ptr[AW-1:0]];

   assign bus.m_valid = ~empty;
   assign bus.m_first = ~empty & fifo_first[rd_ptr[AW-1:0]] & (xfer_ptr == '0);
   assign bus.m_last  = ~empty & fifo_last[rd_ptr[AW-1:0]] & (xfer_ptr == LAST_GRP);

   always_comb begin
      bus.m_data = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (!empty && xfer_ptr == GW'(g)) bus.m_data = head[g*S*W +: S*W];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr[AW-1:0]]  <= bus.core_out_data;
         fifo_first[wr_ptr[AW-1:0]] <= bus.core_out_start;
         fifo_last[wr_ptr[AW-1:0]]  <= out_is_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         xfer_ptr         <= '0;
         out_cnt          <= '0;
         bus.err_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (bus.m_valid && bus.m_ready)
            xfer_ptr <= (xfer_ptr == LAST_GRP) ? '0 : xfer_ptr + 1'b1;
         if (bus.core_out_valid) begin
            out_cnt <= out_is_last ? '0 : out_idx + 1'b1;
            if (full && !pop) bus.err_overflow <= 1'b1;
         end
      end
   end
endmodule
